mips32_program_loader: RTL

Byte-stream boot loader that sits directly upstream of the pipelined MIPS32 core. It receives a framed program image over a valid/ready byte interface and assembles big-endian 32-bit words. It writes those words into the core's 501-word memory through a single write port. It releases the core with `cpu_run` only after the frame's range and checksum checks pass.

---
 rtl/mips32_program_loader.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mips32_program_loader.sv
// rtl/mips32_program_loader.sv - framed byte-stream boot loader for the MIPS32 core memory
//
// Receives a framed program image over a valid/ready byte interface, assembles
// big-endian 32-bit words and writes them into the core's word memory. The core
// is released (cpu_run) only after the range and checksum checks pass.
//
// Ports:
//   clk1       in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   restart    in   synchronous abort/clear back to IDLE
//   in_valid   in   byte available
//   in_data    in   byte value [7:0]
//   in_ready   out  loader can accept a byte
//   mem_we     out  one-cycle memory write strobe
//   mem_addr   out  word address [ADDR_W-1:0]
//   mem_wdata  out  word data [31:0]
//   cpu_run    out  core release (level)
//   load_done  out  frame accepted (sticky)
//   load_err   out  frame rejected (sticky)
//   err_code   out  0 none, 1 range, 2 checksum, 3 timeout
module mips32_program_loader #(
  parameter int ADDR_W         = 9,
  parameter int MEM_DEPTH      = 501,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   DEPTH17 = 17'(MEM_DEPTH);

  state_t        state, state_next;
  logic [1:0]    err_next;
  logic          accept;
  logic          in_frame;
  logic          timeout_hit;

  logic [1:0]    hdr_cnt;
  logic [1:0]    byte_cnt;
  logic [23:0]   shreg;
  logic [15:0]   start_addr;
  logic [15:0]   word_cnt;
  logic [15:0]   word_idx;
  logic [7:0]    sum;
  logic [TW-1:0] idle_cnt;

  logic [31:0]   cur_word;
  logic [16:0]   range_end;
  logic [7:0]    sum_next;

  // The same shift register serves the header (start/count) and the data words;
  // cur_word is the full 32-bit value completed by the byte on the bus.
  assign cur_word  = {shreg, in_data};
  assign range_end = {1'b0, cur_word[31:16]} + {1'b0, cur_word[15:0]};
  assign sum_next  = sum + in_data;

  assign in_frame  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign in_ready  = (state == S_IDLE) || in_frame;
  // restart wins over byte acceptance: a byte presented with restart is not consumed.
  assign accept    = in_valid && in_ready && !restart;
  // A byte accepted on the same edge takes priority over the timeout.
  assign timeout_hit = in_frame && !accept && (idle_cnt == T_LAST);

  assign cpu_run   = (state == S_DONE);
  assign load_done = (state == S_DONE);
  assign load_err  = (state == S_ERR);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      err_code <= 2'd0;
    end else begin
      state    <= state_next;
      err_code <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    err_next   = err_code;
    if (restart) begin
      state_next = S_IDLE;
      err_next   = 2'd0;
    end else if (accept) begin
      case (state)
        S_IDLE: begin
          if (in_data == 8'hA5) state_next = S_HDR;
        end
        S_HDR: begin
          if (hdr_cnt == 2'd3) begin
            if ((cur_word[15:0] == 16'd0) || (range_end > DEPTH17)) begin
              state_next = S_ERR;
              err_next   = 2'd1;
            end else begin
              state_next = S_DATA;
            end
          end
        end
        S_DATA: begin
          if ((byte_cnt == 2'd3) && (word_idx == word_cnt - 16'd1)) state_next = S_CSUM;
        end
        S_CSUM: begin
          if (in_data == sum) begin
            state_next = S_DONE;
          end else begin
            state_next = S_ERR;
            err_next   = 2'd2;
          end
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      state_next = S_ERR;
      err_next   = 2'd3;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      hdr_cnt    <= 2'd0;
      byte_cnt   <= 2'd0;
      shreg      <= 24'd0;
      start_addr <= 16'd0;
      word_cnt   <= 16'd0;
      word_idx   <= 16'd0;
      sum        <= 8'd0;
      idle_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        hdr_cnt  <= 2'd0;
        byte_cnt <= 2'd0;
        word_idx <= 16'd0;
        sum      <= 8'd0;
        idle_cnt <= '0;
      end else begin
        if (accept || !in_frame) idle_cnt <= '0;
        else                     idle_cnt <= idle_cnt + TW'(1);

        if (accept) begin
          case (state)
            S_IDLE: begin
              hdr_cnt  <= 2'd0;
              byte_cnt <= 2'd0;
              word_idx <= 16'd0;
              sum      <= 8'd0;
            end
            S_HDR: begin
              shreg   <= {shreg[15:0], in_data};
              hdr_cnt <= hdr_cnt + 2'd1;
              sum     <= sum_next;
              if (hdr_cnt == 2'd3) begin
                start_addr <= cur_word[31:16];
                word_cnt   <= cur_word[15:0];
              end
            end
            S_DATA: begin
              shreg    <= {shreg[15:0], in_data};
              byte_cnt <= byte_cnt + 2'd1;
              sum      <= sum_next;
              if (byte_cnt == 2'd3) begin
                mem_we    <= 1'b1;
                // Range check guarantees start_addr + word_idx < MEM_DEPTH.
                mem_addr  <= ADDR_W'(start_addr + word_idx);
                mem_wdata <= cur_word;
                word_idx  <= word_idx + 16'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
